counter_scheduler: RTL and testbench

Sequencer for a bank of NUM_LINES pulse counters that share one integration window. It holds the counters in reset, opens a gate of programmable length, then snapshots every count into shadow registers. It then streams the snapshots out one line at a time over a valid/ready handshake and re-arms for the next frame. It sits between the counter bank and the host readout/packetiser logic.

---
 rtl/counter_scheduler.sv | 136 +++++++++++++
 tb/tb_counter_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// Frame sequencer for a bank of pulse counters: clear, gate for a programmed
// number of cycles, snapshot every count, then stream the snapshots over valid/ready.
module counter_scheduler #(
  parameter int RESOLUTION = 64,
  parameter int NUM_LINES  = 4,
  parameter int LINE_BITS  = 2,
  parameter int FRAME_BITS = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [RESOLUTION-1:0]           integration_time,
  input  logic [NUM_LINES*RESOLUTION-1:0] counter_values,
  input  logic [NUM_LINES-1:0]            counter_overflow,
  output logic                            counter_clear,
  output logic [RESOLUTION-1:0]           out_data,
  output logic [LINE_BITS-1:0]            out_line,
  output logic                            out_saturated,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FRAME_BITS-1:0]           frame_id,
  output logic                            busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, INTEGRATE, LATCH, READOUT} state_t;

  localparam logic [RESOLUTION-1:0] ONE      = RESOLUTION'(1);
  localparam logic [LINE_BITS-1:0]  LAST_IDX = LINE_BITS'(NUM_LINES - 1);

  state_t                  state_reg, state_next;
  logic [RESOLUTION-1:0]   gate_len_reg;
  logic [RESOLUTION-1:0]   timer_reg;
  logic [LINE_BITS-1:0]    index_reg;
  logic [LINE_BITS-1:0]    index_next;
  logic [RESOLUTION-1:0]   shadow_reg [NUM_LINES];
  logic [NUM_LINES-1:0]    shadow_ovf_reg;
  logic [RESOLUTION-1:0]   count_in [NUM_LINES];
  logic [RESOLUTION-1:0]   out_data_reg;
  logic [LINE_BITS-1:0]    out_line_reg;
  logic                    out_saturated_reg;
  logic                    out_last_reg;
  logic                    out_valid_reg;
  logic [FRAME_BITS-1:0]   frame_id_reg;
  logic                    gate_done;
  logic                    xfer;

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_unpack
      assign count_in[gi] = counter_values[gi*RESOLUTION +: RESOLUTION];
    end
  endgenerate

  assign gate_done  = (timer_reg == gate_len_reg - ONE);
  assign xfer       = out_valid_reg && out_ready;
  assign index_next = index_reg + LINE_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (enable) state_next = CLEAR;
      CLEAR:     state_next = INTEGRATE;
      INTEGRATE: if (gate_done) state_next = LATCH;
      LATCH:     state_next = READOUT;
      READOUT:   if (xfer && out_last_reg) state_next = enable ? CLEAR : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The counters are only released while gating; every other state holds them at zero.
  assign counter_clear = (state_reg != INTEGRATE);
  assign busy          = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_len_reg      <= ONE;
      timer_reg         <= '0;
      index_reg         <= '0;
      shadow_ovf_reg    <= '0;
      out_data_reg      <= '0;
      out_line_reg      <= '0;
      out_saturated_reg <= 1'b0;
      out_last_reg      <= 1'b0;
      out_valid_reg     <= 1'b0;
      frame_id_reg      <= '0;
      for (int i = 0; i < NUM_LINES; i++) shadow_reg[i] <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          // A zero gate would never terminate the compare, so run it as one cycle.
          gate_len_reg <= (integration_time == '0) ? ONE : integration_time;
          timer_reg    <= '0;
        end
        INTEGRATE: timer_reg <= timer_reg + ONE;
        LATCH: begin
          for (int i = 0; i < NUM_LINES; i++) shadow_reg[i] <= count_in[i];
          shadow_ovf_reg    <= counter_overflow;
          index_reg         <= '0;
          out_valid_reg     <= 1'b1;
          out_data_reg      <= count_in[0];
          out_line_reg      <= '0;
          out_saturated_reg <= counter_overflow[0];
          out_last_reg      <= (NUM_LINES == 1);
        end
        READOUT: begin
          if (xfer) begin
            if (out_last_reg) begin
              out_valid_reg <= 1'b0;
              frame_id_reg  <= frame_id_reg + FRAME_BITS'(1);
            end else begin
              index_reg         <= index_next;
              out_data_reg      <= shadow_reg[index_next];
              out_line_reg      <= index_next;
              out_saturated_reg <= shadow_ovf_reg[index_next];
              out_last_reg      <= (index_next == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data      = out_data_reg;
  assign out_line      = out_line_reg;
  assign out_saturated = out_saturated_reg;
  assign out_last      = out_last_reg;
  assign out_valid     = out_valid_reg;
  assign frame_id      = frame_id_reg;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler with a behavioural counter bank that
// counts every edge where counter_clear is low (line i adds step[i] per edge).
module tb_counter_scheduler;

  localparam int RES = 64;
  localparam int NL  = 4;
  localparam int LB  = 2;
  // Narrow frame_id so the wrap-around fits in a short run.
  localparam int FB  = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                out_ready = 1'b0;
  logic [RES-1:0]      integration_time = '0;
  logic [NL*RES-1:0]   counter_values;
  logic [NL-1:0]       counter_overflow = '0;
  logic                counter_clear;
  logic [RES-1:0]      out_data;
  logic [LB-1:0]       out_line;
  logic                out_saturated;
  logic                out_last;
  logic                out_valid;
  logic [FB-1:0]       frame_id;
  logic                busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          step [NL];
  logic [63:0] cnt [NL];
  int          clear_low_total;
  logic [63:0] exp_data [NL];
  logic [NL-1:0] exp_sat;
  int          ready_pat [4];
  int          c0;
  int          n;

  always #5 clk = ~clk;

  counter_scheduler #(
    .RESOLUTION(RES), .NUM_LINES(NL), .LINE_BITS(LB), .FRAME_BITS(FB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .integration_time(integration_time),
    .counter_values(counter_values), .counter_overflow(counter_overflow),
    .counter_clear(counter_clear),
    .out_data(out_data), .out_line(out_line), .out_saturated(out_saturated),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .frame_id(frame_id), .busy(busy)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (reset || counter_clear) cnt[i] <= '0;
      else                        cnt[i] <= cnt[i] + 64'(step[i]);
    end
  end
  assign counter_values = {cnt[3], cnt[2], cnt[1], cnt[0]};

  always_ff @(posedge clk) begin
    if (reset)               clear_low_total <= 0;
    else if (!counter_clear) clear_low_total <= clear_low_total + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int gl, input logic [NL-1:0] sat);
    for (int i = 0; i < NL; i++) exp_data[i] = 64'(gl * step[i]);
    exp_sat = sat;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Drive out_ready from ready_pat each cycle and check every valid beat in order.
  task automatic collect(input int frame);
    int k = 0;
    int p = 0;
    int cyc = 0;
    logic [1:0] ki;
    while (k < NL && cyc < 300) begin
      out_ready = (ready_pat[p % 4] != 0);
      p++;
      ki = 2'(k);
      if (out_valid) begin
        check("line", 64'(out_line), 64'(k));
        check("data", out_data, exp_data[ki]);
        check("sat", 64'(out_saturated), 64'(exp_sat[ki]));
        check("last", 64'(out_last), 64'(k == NL - 1));
        check("frame_id", 64'(frame_id), 64'(frame % 16));
        if (out_ready) begin
          $display("beat frame=%0d line=%0d data=%0d sat=%0b last=%0b",
                   frame, out_line, out_data, out_saturated, out_last);
          k++;
        end
      end
      tick();
      cyc++;
    end
    check("beats", 64'(k), 64'(NL));
    check("valid_drop", 64'(out_valid), 64'(0));
    check("frame_inc", 64'(frame_id), 64'((frame + 1) % 16));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NL; i++) step[i] = 1;
    ready_pat = '{1, 1, 1, 1};
    repeat (3) tick();
    check("rst_clear", 64'(counter_clear), 64'(1));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame", 64'(frame_id), 64'(0));
    check("rst_data", out_data, 64'(0));
    check("rst_line", 64'(out_line), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_sat", 64'(out_saturated), 64'(0));
    reset = 1'b0;
    tick();

    // Basic frame: gate of 5, latency from busy to first valid is gate+2.
    integration_time = 5;
    out_ready = 1'b1;
    c0 = clear_low_total;
    start();
    check("busy_up", 64'(busy), 64'(1));
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(7));
    set_exp(5, 4'b0000);
    collect(0);
    check("gate5", 64'(clear_low_total - c0), 64'(5));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_clear", 64'(counter_clear), 64'(1));

    // Back-pressure with enable held; next frame starts right after the last handshake.
    for (int i = 0; i < NL; i++) step[i] = i + 1;
    ready_pat = '{1, 0, 0, 1};
    enable = 1'b1;
    c0 = clear_low_total;
    set_exp(5, 4'b0000);
    collect(1);
    check("gate_bp", 64'(clear_low_total - c0), 64'(5));
    check("clear_state_busy", 64'(busy), 64'(1));
    check("clear_state_clr", 64'(counter_clear), 64'(1));
    tick();
    check("next_gate_open", 64'(counter_clear), 64'(0));

    // Drop enable mid-INTEGRATE: frame still completes, then IDLE.
    enable = 1'b0;
    ready_pat = '{1, 1, 1, 1};
    c0 = clear_low_total;
    collect(2);
    check("gate_drop", 64'(clear_low_total - c0), 64'(5));
    repeat (3) tick();
    check("drop_idle_busy", 64'(busy), 64'(0));
    check("drop_idle_clr", 64'(counter_clear), 64'(1));

    // Zero gate runs as one cycle.
    integration_time = 0;
    c0 = clear_low_total;
    start();
    set_exp(1, 4'b0000);
    collect(3);
    check("gate_zero", 64'(clear_low_total - c0), 64'(1));

    // integration_time changed during the gate only affects the next frame.
    integration_time = 3;
    c0 = clear_low_total;
    start();
    tick();
    integration_time = 9;
    set_exp(3, 4'b0000);
    collect(4);
    check("gate_old", 64'(clear_low_total - c0), 64'(3));
    c0 = clear_low_total;
    start();
    set_exp(9, 4'b0000);
    collect(5);
    check("gate_new", 64'(clear_low_total - c0), 64'(9));

    // Overflow flags follow their line and clear on the next frame.
    integration_time = 2;
    counter_overflow = 4'b0100;
    start();
    set_exp(2, 4'b0100);
    collect(6);
    counter_overflow = 4'b0000;
    start();
    set_exp(2, 4'b0000);
    collect(7);

    // Reset in the middle of a stalled readout.
    out_ready = 1'b0;
    start();
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("mid_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("mid_line", 64'(out_line), 64'(1));
    check("mid_frame", 64'(frame_id), 64'(8));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", 64'(out_valid), 64'(0));
    check("mrst_frame", 64'(frame_id), 64'(0));
    check("mrst_clear", 64'(counter_clear), 64'(1));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_line", 64'(out_line), 64'(0));
    tick();

    // 2^FB + 1 back-to-back frames: frame_id wraps to 0.
    integration_time = 1;
    ready_pat = '{1, 1, 1, 1};
    set_exp(1, 4'b0000);
    enable = 1'b1;
    for (int f = 0; f <= 16; f++) begin
      if (f == 16) enable = 1'b0;
      collect(f);
    end
    check("wrap_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
